// File: rtl/tap_ir_unit.sv
// rtl/tap_ir_unit.sv - JTAG IR shift/hold stages with registered decode; TAP_IDCODE_EN adds IDCODE.
module tap_ir_unit #(
    parameter int                  IR_WIDTH        = 4,
    parameter logic [IR_WIDTH-1:0] EXTEST_OP       = IR_WIDTH'(0),
    parameter logic [IR_WIDTH-1:0] SAMPLE_OP       = IR_WIDTH'(1),
    parameter logic [IR_WIDTH-1:0] PRELOAD_OP      = IR_WIDTH'(2),
    parameter logic [IR_WIDTH-1:0] LOAD_PROGRAM_OP = IR_WIDTH'(3),
    parameter logic [IR_WIDTH-1:0] IDCODE_OP       = IR_WIDTH'(4)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                testLogicReset_i,
    input  logic                captureIr_i,
    input  logic                shiftIr_i,
    input  logic                updateIr_i,
    input  logic                tdi_i,
    output logic                irTdo_o,
    output logic [IR_WIDTH-1:0] irInstruction_o,
    output logic                scanEnable_o,
    output logic                bypassEnable_o,
    output logic [1:0]          mux_o,
    output logic                extest_mode_o,
    output logic                sample_mode_o,
    output logic                preload_mode_o,
    output logic                loadProgram_mode_o,
    output logic                idcode_mode_o,
    output logic                unknownInstr_o,
    output logic                instrChanged_o
);

    localparam logic [IR_WIDTH-1:0] BYPASS_OP = '1;
`ifdef TAP_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] RESET_OP = IDCODE_OP;
`else
    localparam logic [IR_WIDTH-1:0] RESET_OP = BYPASS_OP;
`endif

    localparam bit OPS_DISTINCT =
        (EXTEST_OP != SAMPLE_OP)        && (EXTEST_OP != PRELOAD_OP)     &&
        (EXTEST_OP != LOAD_PROGRAM_OP)  && (EXTEST_OP != IDCODE_OP)      &&
        (SAMPLE_OP != PRELOAD_OP)       && (SAMPLE_OP != LOAD_PROGRAM_OP) &&
        (SAMPLE_OP != IDCODE_OP)        && (PRELOAD_OP != LOAD_PROGRAM_OP) &&
        (PRELOAD_OP != IDCODE_OP)       && (LOAD_PROGRAM_OP != IDCODE_OP);
    localparam bit OPS_NOT_BYPASS =
        (EXTEST_OP != BYPASS_OP) && (SAMPLE_OP != BYPASS_OP) &&
        (PRELOAD_OP != BYPASS_OP) && (LOAD_PROGRAM_OP != BYPASS_OP) &&
        (IDCODE_OP != BYPASS_OP);

    generate
        if (IR_WIDTH < 2 || IR_WIDTH > 8) begin : g_bad_width
            $error("tap_ir_unit: IR_WIDTH must be in 2..8");
        end
        if (!OPS_DISTINCT || !OPS_NOT_BYPASS) begin : g_bad_opcodes
            $error("tap_ir_unit: opcodes must be distinct and not all-ones");
        end
    endgenerate

    logic [IR_WIDTH-1:0] sr, sr_next;
    logic [IR_WIDTH-1:0] ir, ir_next;
    logic                chg_next;

    logic       d_scan, d_bypass, d_ext, d_samp, d_pre, d_lp, d_idc, d_unk;
    logic [1:0] d_mux;

    always_comb begin
        sr_next = sr;
        if (rst_i || testLogicReset_i) begin
            sr_next = '1;
        end else if (captureIr_i) begin
            sr_next = IR_WIDTH'(2'b01);
        end else if (shiftIr_i) begin
            sr_next = {tdi_i, sr[IR_WIDTH-1:1]};
        end
    end

    // Pulse on real value changes only; rst_i itself keeps the pulse low.
    always_comb begin
        ir_next  = ir;
        chg_next = 1'b0;
        if (rst_i) begin
            ir_next = RESET_OP;
        end else if (testLogicReset_i) begin
            ir_next  = RESET_OP;
            chg_next = (ir != RESET_OP);
        end else if (updateIr_i) begin
            ir_next  = sr;
            chg_next = (sr != ir);
        end
    end

    // Decoding ir_next lets every control flop switch on the same edge as ir.
    always_comb begin
        d_scan   = 1'b0;
        d_bypass = 1'b0;
        d_mux    = 2'b11;
        d_ext    = 1'b0;
        d_samp   = 1'b0;
        d_pre    = 1'b0;
        d_lp     = 1'b0;
        d_idc    = 1'b0;
        d_unk    = 1'b0;
        case (ir_next)
            EXTEST_OP: begin
                d_scan = 1'b1;
                d_mux  = 2'b01;
                d_ext  = 1'b1;
            end
            SAMPLE_OP: begin
                d_scan = 1'b1;
                d_mux  = 2'b01;
                d_samp = 1'b1;
            end
            PRELOAD_OP: begin
                d_scan = 1'b1;
                d_mux  = 2'b01;
                d_pre  = 1'b1;
            end
            LOAD_PROGRAM_OP: begin
                d_scan = 1'b1;
                d_mux  = 2'b01;
                d_lp   = 1'b1;
            end
`ifdef TAP_IDCODE_EN
            IDCODE_OP: begin
                d_mux = 2'b10;
                d_idc = 1'b1;
            end
`endif
            BYPASS_OP: begin
                d_bypass = 1'b1;
            end
            default: begin
                d_bypass = 1'b1;
                d_unk    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr             <= '1;
            ir             <= RESET_OP;
            instrChanged_o <= 1'b0;
        end else begin
            sr             <= sr_next;
            ir             <= ir_next;
            instrChanged_o <= chg_next;
        end
        scanEnable_o       <= d_scan;
        bypassEnable_o     <= d_bypass;
        mux_o              <= d_mux;
        extest_mode_o      <= d_ext;
        sample_mode_o      <= d_samp;
        preload_mode_o     <= d_pre;
        loadProgram_mode_o <= d_lp;
        idcode_mode_o      <= d_idc;
        unknownInstr_o     <= d_unk;
    end

    assign irTdo_o         = sr[0];
    assign irInstruction_o = ir;

endmodule

// File: tb/tb_tap_ir_unit.sv
// tb/tb_tap_ir_unit.sv - scoreboard bench for tap_ir_unit with IR_WIDTH=4 and default opcodes.
module tb_tap_ir_unit;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       tlr = 1'b0;
    logic       cap = 1'b0;
    logic       shf = 1'b0;
    logic       upd = 1'b0;
    logic       tdi = 1'b0;
    logic       tdo;
    logic [3:0] instr;
    logic       scan, byp, ext, samp, pre, lp, idc, unk, chg;
    logic [1:0] mux;

    tap_ir_unit #(.IR_WIDTH(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .testLogicReset_i(tlr),
        .captureIr_i(cap), .shiftIr_i(shf), .updateIr_i(upd), .tdi_i(tdi),
        .irTdo_o(tdo), .irInstruction_o(instr), .scanEnable_o(scan),
        .bypassEnable_o(byp), .mux_o(mux), .extest_mode_o(ext),
        .sample_mode_o(samp), .preload_mode_o(pre), .loadProgram_mode_o(lp),
        .idcode_mode_o(idc), .unknownInstr_o(unk), .instrChanged_o(chg)
    );

    always #5 clk = ~clk;

    typedef enum int {K_BYP, K_EXT, K_SAM, K_PRE, K_LP, K_IDC, K_UNK} kind_t;

`ifdef TAP_IDCODE_EN
    localparam logic [3:0] RST_OP = 4'h4;
    localparam kind_t      RST_K  = K_IDC;
    localparam kind_t      OP4_K  = K_IDC;
    localparam logic       RST_TO_F_CHG = 1'b1;
`else
    localparam logic [3:0] RST_OP = 4'hF;
    localparam kind_t      RST_K  = K_BYP;
    localparam kind_t      OP4_K  = K_UNK;
    localparam logic       RST_TO_F_CHG = 1'b0;
`endif

    typedef struct {
        int          cyc;
        string       name;
        logic [15:0] v;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // {scan, bypass, mux[1:0], ext, samp, pre, lp, idc, unk}
    function automatic logic [9:0] dec(input kind_t k);
        case (k)
            K_EXT:   return 10'b1_0_01_100000;
            K_SAM:   return 10'b1_0_01_010000;
            K_PRE:   return 10'b1_0_01_001000;
            K_LP:    return 10'b1_0_01_000100;
            K_IDC:   return 10'b0_0_10_000010;
            K_UNK:   return 10'b0_1_11_000001;
            default: return 10'b0_1_11_000000;
        endcase
    endfunction

    task automatic step(input string name, input logic c_cap, input logic c_shf,
                        input logic c_upd, input logic c_tlr, input logic c_rst,
                        input logic c_tdi, input logic e_tdo, input logic [3:0] e_ir,
                        input kind_t e_k, input logic e_chg);
        exp_t e;
        cap = c_cap; shf = c_shf; upd = c_upd; tlr = c_tlr; rst_i = c_rst; tdi = c_tdi;
        e.cyc  = cyc + 1;
        e.name = name;
        e.v    = {e_tdo, e_ir, dec(e_k), e_chg};
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [15:0] act;
        act = {tdo, instr, scan, byp, mux, ext, samp, pre, lp, idc, unk, chg};
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_checks++;
            if (e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: sample missed at cycle %0d (due %0d)", e.name, cyc, e.cyc);
            end else if (act !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b required %b (tdo,ir,scan,byp,mux,ext,samp,pre,lp,idc,unk,chg)",
                         e.name, act, e.v);
            end
        end
    end

    initial begin
        step("reset1", 0,0,0,0,1,0, 1, RST_OP, RST_K, 0);
        step("reset2", 0,0,0,0,1,0, 1, RST_OP, RST_K, 0);
        step("idle",   0,0,0,0,0,0, 1, RST_OP, RST_K, 0);

        step("cap_a",  1,0,0,0,0,0, 1, RST_OP, RST_K, 0);
        step("sh_a1",  0,1,0,0,0,0, 0, RST_OP, RST_K, 0);
        step("sh_a2",  0,1,0,0,0,0, 0, RST_OP, RST_K, 0);
        step("sh_a3",  0,1,0,0,0,0, 0, RST_OP, RST_K, 0);
        step("sh_a4",  0,1,0,0,0,0, 0, RST_OP, RST_K, 0);
        step("upd_ext",0,0,1,0,0,0, 0, 4'h0, K_EXT, 1);
        step("ext_hold",0,0,0,0,0,0, 0, 4'h0, K_EXT, 0);

        step("cap_b",  1,0,0,0,0,0, 1, 4'h0, K_EXT, 0);
        step("sh_b1",  0,1,0,0,0,1, 0, 4'h0, K_EXT, 0);
        step("sh_b2",  0,1,0,0,0,1, 0, 4'h0, K_EXT, 0);
        step("sh_b3",  0,1,0,0,0,0, 0, 4'h0, K_EXT, 0);
        step("sh_b4",  0,1,0,0,0,0, 1, 4'h0, K_EXT, 0);
        step("no_upd", 0,0,0,0,0,0, 1, 4'h0, K_EXT, 0);
        step("upd_lp", 0,0,1,0,0,0, 1, 4'h3, K_LP, 1);
        step("upd_same",0,0,1,0,0,0, 1, 4'h3, K_LP, 0);

        step("sh_c1",  0,1,0,0,0,1, 1, 4'h3, K_LP, 0);
        step("sh_c2",  0,1,0,0,0,0, 0, 4'h3, K_LP, 0);
        step("sh_c3",  0,1,0,0,0,0, 0, 4'h3, K_LP, 0);
        step("sh_c4",  0,1,0,0,0,1, 1, 4'h3, K_LP, 0);
        step("upd_unk",0,0,1,0,0,0, 1, 4'h9, K_UNK, 1);

        step("cap_shf",1,1,0,0,0,0, 1, 4'h9, K_UNK, 0);
        step("tlr_upd",0,0,1,1,0,0, 1, RST_OP, RST_K, 1);
        step("tlr_again",0,0,0,1,0,0, 1, RST_OP, RST_K, 0);

        step("cap_d",  1,0,0,0,0,0, 1, RST_OP, RST_K, 0);
        step("sh_d1",  0,1,0,0,0,0, 0, RST_OP, RST_K, 0);
        step("rst_mid",0,0,0,0,1,0, 1, RST_OP, RST_K, 0);
        step("upd_post_rst",0,0,1,0,0,0, 1, 4'hF, K_BYP, RST_TO_F_CHG);

        step("cap_e",  1,0,0,0,0,0, 1, 4'hF, K_BYP, 0);
        step("sh_e1",  0,1,0,0,0,0, 0, 4'hF, K_BYP, 0);
        step("sh_e2",  0,1,0,0,0,0, 0, 4'hF, K_BYP, 0);
        step("sh_e3",  0,1,0,0,0,1, 0, 4'hF, K_BYP, 0);
        step("sh_e4",  0,1,0,0,0,0, 0, 4'hF, K_BYP, 0);
        step("upd_op4",0,0,1,0,0,0, 0, 4'h4, OP4_K, 1);
        step("op4_hold",0,0,0,0,0,0, 0, 4'h4, OP4_K, 0);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
